// File: rtl/tb_uart_xcvr.sv
// tb_uart_xcvr: host-side 8N1 UART endpoint for chip-level simulation.
// It drives bytes into the chip RX pad (ser_tx) on a level-held start request
// and decodes bytes that the chip sends on its TX pad (ser_rx).
// The TX and RX paths are fully independent of each other.
module tb_uart_xcvr #(
   parameter int CLKS_PER_BIT = 4167
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_clear_req,
   output logic       ser_tx,
   input  logic       ser_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ------------------------------------------------------------------ TX
   tx_state_t        tx_state, tx_state_nx;
   logic [CNT_W-1:0] tx_cnt, tx_cnt_nx;
   logic [2:0]       tx_idx, tx_idx_nx;
   logic [7:0]       tx_shreg, tx_shreg_nx;

   // TX state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shreg <= '0;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         tx_idx   <= tx_idx_nx;
         tx_shreg <= tx_shreg_nx;
      end
   end

   // TX next state; outputs decode straight from the state so that the start
   // bit and busy appear on the accepting edge and reset forces the line idle
   // asynchronously. DONE is only left with tx_start low, which re-arms IDLE.
   always_comb begin
      tx_state_nx  = tx_state;
      tx_cnt_nx    = tx_cnt;
      tx_idx_nx    = tx_idx;
      tx_shreg_nx  = tx_shreg;
      tx_busy      = 1'b0;
      tx_clear_req = 1'b0;
      ser_tx       = 1'b1;
      case (tx_state)
         TX_IDLE: begin
            if (tx_start) begin
               tx_state_nx = TX_START;
               tx_cnt_nx   = '0;
               tx_shreg_nx = tx_data;
            end
         end
         TX_START: begin
            tx_busy = 1'b1;
            ser_tx  = 1'b0;
            if (tx_cnt == BIT_LAST) begin
               tx_state_nx = TX_DATA;
               tx_cnt_nx   = '0;
               tx_idx_nx   = '0;
            end else begin
               tx_cnt_nx = tx_cnt + 1'b1;
            end
         end
         TX_DATA: begin
            tx_busy = 1'b1;
            ser_tx  = tx_shreg[0];
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_nx   = '0;
               tx_shreg_nx = {1'b0, tx_shreg[7:1]};
               if (tx_idx == 3'd7) begin
                  tx_state_nx = TX_STOP;
               end else begin
                  tx_idx_nx = tx_idx + 1'b1;
               end
            end else begin
               tx_cnt_nx = tx_cnt + 1'b1;
            end
         end
         TX_STOP: begin
            tx_busy = 1'b1;
            if (tx_cnt == BIT_LAST) begin
               tx_state_nx = TX_DONE;
               tx_cnt_nx   = '0;
            end else begin
               tx_cnt_nx = tx_cnt + 1'b1;
            end
         end
         TX_DONE: begin
            tx_clear_req = 1'b1;
            if (!tx_start) begin
               tx_state_nx = TX_IDLE;
            end
         end
         default: tx_state_nx = TX_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ RX
   rx_state_t        rx_state, rx_state_nx;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_nx;
   logic [2:0]       rx_idx, rx_idx_nx;
   logic [7:0]       rx_shreg, rx_shreg_nx;
   logic [7:0]       rx_data_nx;
   logic             rx_valid_nx, rx_err_nx;
   logic             rx_sync1, rx_sync2, rx_prev;

   // Two-flop synchronizer plus previous-value flop for falling-edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync1 <= 1'b1;
         rx_sync2 <= 1'b1;
         rx_prev  <= 1'b1;
      end else begin
         rx_sync1 <= ser_rx;
         rx_sync2 <= rx_sync1;
         rx_prev  <= rx_sync2;
      end
   end

   // RX state, datapath and registered result/pulse outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state     <= RX_IDLE;
         rx_cnt       <= '0;
         rx_idx       <= '0;
         rx_shreg     <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_state     <= rx_state_nx;
         rx_cnt       <= rx_cnt_nx;
         rx_idx       <= rx_idx_nx;
         rx_shreg     <= rx_shreg_nx;
         rx_data      <= rx_data_nx;
         rx_valid     <= rx_valid_nx;
         rx_frame_err <= rx_err_nx;
      end
   end

   // RX next state: start-bit confirm at half bit, then sample every bit period.
   // An edge needs the line to be 1 beforehand, so after a bad stop bit the
   // receiver waits for the line to return high.
   always_comb begin
      rx_state_nx = rx_state;
      rx_cnt_nx   = rx_cnt;
      rx_idx_nx   = rx_idx;
      rx_shreg_nx = rx_shreg;
      rx_data_nx  = rx_data;
      rx_valid_nx = 1'b0;
      rx_err_nx   = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_sync2) begin
               rx_state_nx = RX_START;
               rx_cnt_nx   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt == BIT_HALF) begin
               rx_cnt_nx = '0;
               rx_idx_nx = '0;
               if (rx_sync2) begin
                  rx_state_nx = RX_IDLE;
               end else begin
                  rx_state_nx = RX_DATA;
               end
            end else begin
               rx_cnt_nx = rx_cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nx   = '0;
               rx_shreg_nx = {rx_sync2, rx_shreg[7:1]};
               if (rx_idx == 3'd7) begin
                  rx_state_nx = RX_STOP;
               end else begin
                  rx_idx_nx = rx_idx + 1'b1;
               end
            end else begin
               rx_cnt_nx = rx_cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nx   = '0;
               rx_state_nx = RX_IDLE;
               if (rx_sync2) begin
                  rx_data_nx  = rx_shreg;
                  rx_valid_nx = 1'b1;
               end else begin
                  rx_err_nx = 1'b1;
               end
            end else begin
               rx_cnt_nx = rx_cnt + 1'b1;
            end
         end
         default: rx_state_nx = RX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_tb_uart_xcvr.sv
// Self-checking bench for tb_uart_xcvr with CLKS_PER_BIT = 4.
// Expected serial waveforms and received bytes come from a frame model
// (start 0, data LSB first, stop) computed from the byte value.
module tb_tb_uart_xcvr;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_busy, tx_clear_req, ser_tx;
   logic       ser_rx;
   logic [7:0] rx_data;
   logic       rx_valid, rx_frame_err;

   logic       loop_en = 1'b0;
   logic       drv_rx = 1'b1;

   int         n_pass = 0;
   int         n_total = 0;
   int         valid_cnt = 0;
   int         err_cnt = 0;
   logic [7:0] exp_rx = 8'h00;

   assign ser_rx = loop_en ? ser_tx : drv_rx;

   tb_uart_xcvr #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_busy      (tx_busy),
      .tx_clear_req (tx_clear_req),
      .ser_tx       (ser_tx),
      .ser_rx       (ser_rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err)
   );

   always #5 clk = ~clk;

   // Count cycles on which each receive pulse is high
   always @(negedge clk) begin
      if (rx_valid === 1'b1) valid_cnt++;
      if (rx_frame_err === 1'b1) err_cnt++;
   end

   // Frame model: bit k of an 8N1 frame for byte d with given stop level
   function automatic logic frame_bit(input logic [7:0] d, input int k, input logic stop);
      if (k == 0) return 1'b0;
      if (k == 9) return stop;
      return logic'((d >> (k - 1)) & 8'h01);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Transmit d, checking every cycle of the frame; hold tx_start for 'hold'
   // extra cycles after the frame, then drop it
   task automatic send_tx(input logic [7:0] d, input int hold);
      int bad;
      tx_data  = d;
      tx_start = 1'b1;
      for (int i = 0; i < 10 * CPB; i++) begin
         @(negedge clk);
         if (i == 5) tx_data = ~d;
         check("tx_bit", 32'(ser_tx), 32'(frame_bit(d, i / CPB, 1'b1)));
         check("tx_busy_hi", 32'(tx_busy), 32'd1);
         check("tx_clr_lo", 32'(tx_clear_req), 32'd0);
      end
      @(negedge clk);
      check("tx_busy_end", 32'(tx_busy), 32'd0);
      check("tx_clr_end", 32'(tx_clear_req), 32'd1);
      check("tx_idle_line", 32'(ser_tx), 32'd1);
      if (hold > 0) begin
         bad = 0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ser_tx !== 1'b1 || tx_busy !== 1'b0 || tx_clear_req !== 1'b1) bad++;
         end
         check("held_start_quiet", 32'(bad), 32'd0);
      end
      tx_start = 1'b0;
      @(negedge clk);
      check("tx_clr_drop", 32'(tx_clear_req), 32'd0);
      check("tx_busy_idle", 32'(tx_busy), 32'd0);
   endtask

   // Drive a frame directly onto ser_rx
   task automatic drive_rx(input logic [7:0] d, input logic stop);
      for (int k = 0; k < 10; k++) begin
         drv_rx = frame_bit(d, k, stop);
         repeat (CPB) @(negedge clk);
      end
      drv_rx = 1'b1;
   endtask

   task automatic check_rx(input string tag, input int v0, input int e0,
                           input int dv, input int de);
      repeat (20) @(negedge clk);
      check({tag, "_valid"}, 32'(valid_cnt - v0), 32'(dv));
      check({tag, "_err"}, 32'(err_cnt - e0), 32'(de));
      check({tag, "_data"}, 32'(rx_data), 32'(exp_rx));
   endtask

   initial begin
      int v0, e0, bad;
      logic [7:0] d;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ser_tx", 32'(ser_tx), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_clr", 32'(tx_clear_req), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_err", 32'(rx_frame_err), 32'd0);
      rst = 1'b0;

      // Reset mid-frame with loopback active: abort is immediate
      loop_en  = 1'b1;
      tx_data  = 8'hC3;
      tx_start = 1'b1;
      repeat (22) @(negedge clk);
      rst = 1'b1;
      tx_start = 1'b0;
      #1;
      check("midrst_ser_tx", 32'(ser_tx), 32'd1);
      check("midrst_busy", 32'(tx_busy), 32'd0);
      check("midrst_clr", 32'(tx_clear_req), 32'd0);
      check("midrst_valid", 32'(rx_valid), 32'd0);
      check("midrst_err", 32'(rx_frame_err), 32'd0);
      v0 = valid_cnt;
      e0 = err_cnt;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ser_tx !== 1'b1 || tx_busy !== 1'b0 || tx_clear_req !== 1'b0) bad++;
      end
      check("post_rst_quiet", 32'(bad), 32'd0);
      check("post_rst_no_valid", 32'(valid_cnt - v0), 32'd0);
      check("post_rst_no_err", 32'(err_cnt - e0), 32'd0);
      check("post_rst_rx_data", 32'(rx_data), 32'd0);

      // 8'h3D with loopback, start dropped as busy falls
      v0 = valid_cnt; e0 = err_cnt;
      send_tx(8'h3D, 0);
      exp_rx = 8'h3D;
      check_rx("loop_3d", v0, e0, 1, 0);

      // Held start for 100 cycles, then re-arm with 8'h0F
      v0 = valid_cnt; e0 = err_cnt;
      send_tx(8'h3D, 100);
      check_rx("held_3d", v0, e0, 1, 0);
      v0 = valid_cnt; e0 = err_cnt;
      send_tx(8'h0F, 3);
      exp_rx = 8'h0F;
      check_rx("loop_0f", v0, e0, 1, 0);

      // Random bytes through loopback
      for (int r = 0; r < 3; r++) begin
         d = 8'($urandom);
         v0 = valid_cnt; e0 = err_cnt;
         send_tx(d, int'($urandom_range(0, 4)));
         exp_rx = d;
         check_rx("loop_rand", v0, e0, 1, 0);
      end
      loop_en = 1'b0;
      repeat (4) @(negedge clk);

      // Framing error: rx_data must keep its previous value
      v0 = valid_cnt; e0 = err_cnt;
      drive_rx(8'hA5, 1'b0);
      check_rx("frame_err", v0, e0, 0, 1);

      // One-cycle glitch, then a good 8'h5A
      v0 = valid_cnt; e0 = err_cnt;
      drv_rx = 1'b0;
      @(negedge clk);
      drv_rx = 1'b1;
      check_rx("glitch", v0, e0, 0, 0);
      v0 = valid_cnt; e0 = err_cnt;
      drive_rx(8'h5A, 1'b1);
      exp_rx = 8'h5A;
      check_rx("after_glitch", v0, e0, 1, 0);

      // Random bytes driven directly onto ser_rx
      for (int r = 0; r < 4; r++) begin
         d = 8'($urandom);
         v0 = valid_cnt; e0 = err_cnt;
         drive_rx(d, 1'b1);
         exp_rx = d;
         check_rx("rx_rand", v0, e0, 1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tb_uart_xcvr.md
# tb_uart_xcvr

Clocked 8N1 UART transceiver used as the host-side serial endpoint in chip-level simulation. It drives a byte into the chip's UART receive pin on a level-held start request. It also decodes bytes the chip transmits on its UART transmit pin. It sits beside the chip model and flash model in the top-level bench, with `ser_tx` tied to the chip's RX pad and `ser_rx` tied to the chip's TX pad.

## Interface
Parameters:
- `CLKS_PER_BIT`, 4167: clock cycles per serial bit (40 MHz / 9600 baud); legal range is 4 or more.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `tx_start` in 1: level transmit request, held high by the stimulus until `tx_busy` falls.
- `tx_data` in 8: byte to send, sampled when a transmit is accepted.
- `tx_busy` out 1: high while a frame is being shifted out.
- `tx_clear_req` out 1: high from the end of a frame until `tx_start` goes low.
- `ser_tx` out 1: serial output; idle level is 1.
- `ser_rx` in 1: serial input, asynchronous to `clk`.
- `rx_data` out 8: last byte received.
- `rx_valid` out 1: one-cycle pulse when `rx_data` is updated.
- `rx_frame_err` out 1: one-cycle pulse when a received stop bit is 0.

## Operation
- Frame format: 8N1. One start bit (0), then 8 data bits LSB first, then one stop bit (1). No parity.
- TX FSM states are IDLE, START, DATA, STOP and DONE.
  - IDLE → START when `tx_start`=1 and the transmitter is armed. `tx_data` is latched and `tx_busy` is set.
  - START → DATA after the start-bit period. DATA → STOP after 8 bit periods. STOP → DONE after the stop-bit period.
  - On entering DONE, `tx_busy`=0 and `tx_clear_req`=1.
  - DONE → IDLE when `tx_start`=0; `tx_clear_req` drops at the same time.
- Re-arm rule: a `tx_start` that stays high never causes a second frame. A new frame requires `tx_start` to go low first.
- `tx_data` changes while busy are ignored; the latched byte is what gets sent.
- RX path:
  - `ser_rx` passes through a 2-flop synchronizer.
  - In IDLE, a synchronized falling edge starts a frame.
  - The line is re-checked at half a bit period. If it is back to 1, the event is treated as a glitch and the receiver returns to IDLE with no output.
  - Each data bit and the stop bit are then sampled every `CLKS_PER_BIT` cycles.
  - At the stop sample: if the stop bit is 1, `rx_data` is updated and `rx_valid` pulses. If it is 0, `rx_data` is left unchanged and `rx_frame_err` pulses.
  - The receiver then returns to IDLE and waits for `ser_rx`=1 before it can detect the next start bit.
- TX and RX are fully independent and may run at the same time. A loopback of `ser_tx` to `ser_rx` is legal.
- Bit counter is 0..`CLKS_PER_BIT`-1, with width set by `$clog2(CLKS_PER_BIT)`. The bit index is 3 bits and wraps only inside the FSM.

## Timing
- Reset values: `ser_tx`=1, `tx_busy`=0, `tx_clear_req`=0, `rx_data`=8'h00, `rx_valid`=0, `rx_frame_err`=0. Both FSMs are in IDLE and the TX path is armed.
- Reset asserted mid-frame aborts immediately. `ser_tx` returns to 1 asynchronously and no `rx_valid` is generated.
- Accept latency: `tx_start` is sampled high at edge N. At edge N, `tx_busy`=1 and `ser_tx`=0 (start bit) both take effect. This is within 2 cycles, as the stimulus requires.
- `tx_busy` stays high for exactly 10×`CLKS_PER_BIT` cycles.
- Each `ser_tx` bit is held for `CLKS_PER_BIT` cycles.
- `tx_clear_req` rises on the same edge that `tx_busy` falls.
- `tx_start` falling on the very cycle `tx_busy` falls still leads to IDLE on the next edge, with no retransmit.
- RX `rx_valid` appears at mid-stop-bit, about 9.5×`CLKS_PER_BIT` cycles after the start edge, plus 2 cycles of synchronizer latency.

## Test plan
- Reset check: assert `rst` mid-frame → `ser_tx`=1, `tx_busy`=0 and all pulses 0 immediately. Deassert → no output activity until `tx_start` is raised.
- Send 61 with `CLKS_PER_BIT`=4 and `tx_start` held: `tx_data`=8'h3D → `ser_tx` bits 0,1,0,1,1,1,1,0,0,1, each 4 cycles. `tx_busy` is high for 40 cycles, then `tx_clear_req`=1 until `tx_start`=0.
- Held start: keep `tx_start`=1 for 100 cycles after the frame → exactly one frame is sent. Drop `tx_start` and raise it again with 8'h0F → bits 0,1,1,1,1,0,0,0,0,1.
- Loopback: tie `ser_tx` to `ser_rx` and send 8'h3D → `rx_valid` pulses once with `rx_data`=8'h3D and `rx_frame_err`=0.
- Framing error: drive a frame of 8'hA5 with stop bit 0 → `rx_frame_err` pulses, `rx_valid` stays 0 and `rx_data` is unchanged.
- Glitch: pulse `ser_rx` low for 1 cycle → no `rx_valid` and no `rx_frame_err`. A following valid 8'h5A frame is received correctly.
